// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared constants and FSM state type for the accumulator drain
package accum_pkg;

    localparam int NUM_OF_ROM = 32;
    localparam int DATA_W     = 24;
    localparam int IDX_W      = $clog2(NUM_OF_ROM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/accum_snapshot_reg.sv
// rtl/accum_snapshot_reg.sv - snapshot bank holding one captured word per accumulator lane
//
// Ports:
//   clk      rising-edge clock
//   cap_en   load every lane of d into the bank on this edge
//   d        live accumulator lanes
//   rd_idx   lane selected for read
//   rd_data  selected snapshot word (combinational read)
module accum_snapshot_reg #(
    parameter int NUM_OF_ROM = accum_pkg::NUM_OF_ROM,
    parameter int DATA_W     = accum_pkg::DATA_W,
    parameter int IDX_W      = accum_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] d [NUM_OF_ROM],
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] bank [NUM_OF_ROM];

    // Contents only matter after a capture, so the bank carries no reset.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int i = 0; i < NUM_OF_ROM; i++) begin
                bank[i] <= d[i];
            end
        end
    end

    assign rd_data = bank[rd_idx];

endmodule

// File: rtl/accum_drain.sv
// rtl/accum_drain.sv - snapshots accumulator lanes on start and drains them as a beat stream
//
// Optional feature: define ACCUM_DRAIN_CHK_EN to append an XOR checksum beat.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        one-cycle request to snapshot result_i and drain it (honoured in IDLE only)
//   result_i     accumulator lanes
//   hold_o       high while a drain is in progress (SEND/CHK/DONE)
//   m_valid, m_ready, m_data, m_idx, m_last, m_chk   output beat handshake and payload
//   done         one-cycle pulse after the final beat is accepted
module accum_drain #(
    parameter int  NUM_OF_ROM = accum_pkg::NUM_OF_ROM,
    parameter int  DATA_W     = accum_pkg::DATA_W,
    localparam int IDX_W      = $clog2(NUM_OF_ROM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] result_i [NUM_OF_ROM],
    output logic              hold_o,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              m_chk,
    output logic              done
);

    import accum_pkg::*;

    drain_state_t      state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [DATA_W-1:0] snap_data;
    logic              cap_en;
    logic              xfer;
    logic              last_lane;

    assign cap_en    = (state == IDLE) && start && !reset;
    assign xfer      = m_valid && m_ready;
    assign last_lane = (idx == IDX_W'(NUM_OF_ROM - 1));

    accum_snapshot_reg #(
        .NUM_OF_ROM (NUM_OF_ROM),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_snapshot (
        .clk     (clk),
        .cap_en  (cap_en),
        .d       (result_i),
        .rd_idx  (idx),
        .rd_data (snap_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_lane) begin
                        idx_nx = '0;
`ifdef ACCUM_DRAIN_CHK_EN
                        state_nx = CHK;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // All beat outputs decode registered state only, so they hold steady while stalled.
    assign hold_o = (state != IDLE);
    assign done   = (state == DONE);
    assign m_idx  = idx;

`ifdef ACCUM_DRAIN_CHK_EN
    logic [DATA_W-1:0] chk_sum;

    // Cleared on the capturing start so each drain checksums only its own lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_sum <= '0;
        end else if (cap_en) begin
            chk_sum <= '0;
        end else if ((state == SEND) && xfer) begin
            chk_sum <= chk_sum ^ snap_data;
        end
    end

    assign m_valid = (state == SEND) || (state == CHK);
    assign m_data  = (state == CHK) ? chk_sum : snap_data;
    assign m_last  = (state == CHK);
    assign m_chk   = (state == CHK);
`else
    assign m_valid = (state == SEND);
    assign m_data  = snap_data;
    assign m_last  = (state == SEND) && last_lane;
    assign m_chk   = 1'b0;
`endif

endmodule
